hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 83 ++++++++
 tb/tb_hazard_control_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush control with load-use and multi-cycle MULT/DIV tracking
// Branch flush outranks load-use, which outranks MULT/DIV busy stalls; counters saturate.
module hazard_control_unit #(
  parameter int MD_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  RS_ID,
  input  logic [4:0]  RT_ID,
  input  logic        UsesRT_ID,
  input  logic        MulDivUse_ID,
  input  logic [4:0]  RT_EX,
  input  logic        MemRead_EX,
  input  logic        MulDivStart_EX,
  input  logic        BranchTaken_EX,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MulDivBusy,
  output logic [1:0]  State,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_LU_STALL = 2'b01;
  localparam logic [1:0] S_MD_STALL = 2'b10;
  localparam logic [2:0] MD_RELOAD  = 3'(MD_LATENCY - 1);

  logic [2:0] md_cnt;
  logic       load_use;
  logic       md_haz;
  logic       stall;
  logic [1:0] state_next;

  assign load_use = MemRead_EX && (RT_EX != 5'd0) &&
                    ((RT_EX == RS_ID) || (UsesRT_ID && (RT_EX == RT_ID)));
  assign MulDivBusy = (md_cnt != 3'd0);
  assign md_haz     = MulDivBusy && MulDivUse_ID;
  // A taken branch squashes the dependent instruction, so its stall is moot.
  assign stall      = !BranchTaken_EX && (load_use || md_haz);

  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;
  assign IF_ID_Flush = BranchTaken_EX;
  assign ID_EX_Flush = BranchTaken_EX || stall;

  always_comb begin
    state_next = S_IDLE;
    if (!BranchTaken_EX) begin
      if (load_use)
        state_next = S_LU_STALL;
      else if (md_haz)
        state_next = S_MD_STALL;
    end
  end

  // Branch flushes leave the count alone: an issued MULT/DIV always completes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      md_cnt <= 3'd0;
    else if (MulDivStart_EX)
      md_cnt <= MD_RELOAD;
    else if (md_cnt != 3'd0)
      md_cnt <= md_cnt - 3'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      State      <= S_IDLE;
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      State <= state_next;
      if (stall && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
      if (BranchTaken_EX && (FlushCount != 16'hFFFF))
        FlushCount <= FlushCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
// Vector table, directed corner sequences and random stimulus against a cycle-stamp reference model.
module tb_hazard_control_unit;

  localparam int MD_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_id, rt_id, rt_ex;
  logic        uses_rt_id, muldiv_use_id, mem_read_ex, muldiv_start_ex, branch_taken_ex;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, muldiv_busy;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

  int checks   = 0;
  int failures = 0;

  // Model: cycle stamp of the last MULT/DIV issue instead of a down-counter.
  int cyc        = 0;
  int last_start = -100;
  int m_state    = 0;
  int m_stall    = 0;
  int m_flush    = 0;

  hazard_control_unit #(.MD_LATENCY(MD_LATENCY)) dut (
    .Clk(clk), .Rst(rst), .RS_ID(rs_id), .RT_ID(rt_id), .UsesRT_ID(uses_rt_id),
    .MulDivUse_ID(muldiv_use_id), .RT_EX(rt_ex), .MemRead_EX(mem_read_ex),
    .MulDivStart_EX(muldiv_start_ex), .BranchTaken_EX(branch_taken_ex),
    .PCWrite(pc_write), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
    .ID_EX_Flush(id_ex_flush), .MulDivBusy(muldiv_busy), .State(state),
    .StallCount(stall_count), .FlushCount(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, rtx;
    logic       uses, mduse, mem, start, br;
    logic [3:0] exp_ctl;
  } vec_t;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_load_use();
    return mem_read_ex && (rt_ex != 0) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

  function automatic bit m_busy();
    int d = cyc - last_start;
    return (d >= 1) && (d < MD_LATENCY);
  endfunction

  function automatic logic [38:0] model_vec();
    bit stl = !branch_taken_ex && (m_load_use() || (m_busy() && muldiv_use_id));
    return {!stl, !stl, branch_taken_ex, branch_taken_ex || stl, m_busy(),
            2'(m_state), 16'(m_stall), 16'(m_flush)};
  endfunction

  function automatic logic [38:0] dut_vec();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, muldiv_busy,
            state, stall_count, flush_count};
  endfunction

  task automatic model_edge();
    bit lu  = m_load_use();
    bit mh  = m_busy() && muldiv_use_id;
    bit stl = !branch_taken_ex && (lu || mh);
    m_state = branch_taken_ex ? 0 : lu ? 1 : mh ? 2 : 0;
    if (stl && m_stall < 65535) m_stall++;
    if (branch_taken_ex && m_flush < 65535) m_flush++;
    if (muldiv_start_ex) last_start = cyc;
    cyc++;
  endtask

  task automatic model_reset();
    last_start = cyc - 100;
    m_state = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input string name);
    @(negedge clk);
    check(name, dut_vec(), model_vec());
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_id = 0; rt_id = 0; rt_ex = 0; uses_rt_id = 0; muldiv_use_id = 0;
    mem_read_ex = 0; muldiv_start_ex = 0; branch_taken_ex = 0;
  endtask

  // Called at posedge+1: pulses Rst entirely between two clock edges.
  task automatic mid_reset(input string name);
    #1 rst = 1'b1;
    #1 check({name, "_async"}, {muldiv_busy, state, stall_count, flush_count}, 35'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 4'b1100};
    vt[1] = '{5, 0, 5, 0, 0, 1, 0, 0, 4'b0001};
    vt[2] = '{0, 0, 0, 0, 0, 1, 0, 0, 4'b1100};
    vt[3] = '{3, 7, 7, 0, 0, 1, 0, 0, 4'b1100};
    vt[4] = '{3, 7, 7, 1, 0, 1, 0, 0, 4'b0001};
    vt[5] = '{5, 0, 5, 0, 0, 0, 0, 0, 4'b1100};
    vt[6] = '{5, 0, 5, 0, 0, 1, 0, 1, 4'b1111};
    vt[7] = '{1, 2, 3, 1, 1, 0, 0, 1, 4'b1111};
    vt[8] = '{1, 2, 3, 1, 1, 0, 0, 0, 4'b1100};
    vt[9] = '{9, 9, 9, 1, 0, 0, 1, 0, 4'b1100};

    rst = 1'b1;
    clear_inputs();
    #2;
    check("reset_state", {muldiv_busy, state, stall_count, flush_count}, 35'd0);
    check("reset_ctl", {pc_write, if_id_write, if_id_flush, id_ex_flush}, 4'b1100);

    // Combinational table while Rst holds MdCnt at zero.
    for (int i = 0; i < 10; i++) begin
      rs_id = vt[i].rs; rt_id = vt[i].rt; rt_ex = vt[i].rtx; uses_rt_id = vt[i].uses;
      muldiv_use_id = vt[i].mduse; mem_read_ex = vt[i].mem;
      muldiv_start_ex = vt[i].start; branch_taken_ex = vt[i].br;
      #1;
      check($sformatf("table_%0d", i), {pc_write, if_id_write, if_id_flush, id_ex_flush},
            vt[i].exp_ctl);
    end

    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Single load-use hazard, then State/StallCount one edge later.
    mem_read_ex = 1; rt_ex = 5; rs_id = 5;
    step("lu_stall");
    clear_inputs();
    #1;
    check("lu_after", {state, stall_count}, {2'b01, 16'd1});
    step("lu_release");

    // MULT/DIV issue with a dependent instruction waiting in ID.
    muldiv_use_id = 1; muldiv_start_ex = 1;
    step("md_issue");
    muldiv_start_ex = 0;
    for (int i = 0; i < MD_LATENCY - 1; i++) step($sformatf("md_busy_%0d", i));
    #1;
    check("md_done", {pc_write, muldiv_busy, stall_count}, {1'b1, 1'b0, 16'd4});
    step("md_free");
    clear_inputs();

    // Branch beats load-use.
    mem_read_ex = 1; rt_ex = 6; rt_id = 6; uses_rt_id = 1; branch_taken_ex = 1;
    step("br_over_lu");
    clear_inputs();
    #1;
    check("br_after", {state, stall_count, flush_count}, {2'b00, 16'd4, 16'd1});

    // Branch during a MULT/DIV count leaves the count running.
    muldiv_start_ex = 1;
    step("br_md_issue");
    muldiv_start_ex = 0; branch_taken_ex = 1; muldiv_use_id = 1;
    step("br_md_flush");
    branch_taken_ex = 0;
    step("br_md_still_busy");
    clear_inputs();
    step("br_md_tail");

    // Asynchronous reset with MdCnt=2 aborts the operation.
    muldiv_start_ex = 1;
    step("abort_issue");
    muldiv_start_ex = 0;
    step("abort_cnt2");
    mid_reset("abort");
    muldiv_use_id = 1;
    for (int i = 0; i < MD_LATENCY; i++) step($sformatf("abort_post_%0d", i));
    clear_inputs();

    // Random traffic with small register indices so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
      rt_ex = 5'($urandom_range(0, 3)); uses_rt_id = 1'($urandom_range(0, 1));
      muldiv_use_id = 1'($urandom_range(0, 1)); mem_read_ex = 1'($urandom_range(0, 1));
      muldiv_start_ex = ($urandom_range(0, 9) == 0);
      branch_taken_ex = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 299) == 0) mid_reset("rand_reset");
      step("random");
    end
    clear_inputs();

    // StallCount saturation under a permanently held load-use.
    mid_reset("sat_pre");
    mem_read_ex = 1; rt_ex = 2; rs_id = 2;
    repeat (65540) @(posedge clk);
    cyc += 65540;
    m_stall = 65535; m_state = 1;
    #1;
    check("sat_hold", {state, stall_count}, {2'b01, 16'hFFFF});
    step("sat_step");
    step("sat_step2");
    clear_inputs();
    step("sat_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
